// File: rtl/ddr3_frame_address_sequencer_if.sv
// Reader address stream: 29-bit {third tag, word address} words with valid/ready handshake.
// The sequencer drives through the master modport; the crop readers sit on the slave side.
interface ddr3_frame_address_sequencer_if;
    logic [28:0] address_out_data;
    logic        address_out_valid;
    logic        address_out_ready;

    modport master (
        output address_out_data,
        output address_out_valid,
        input  address_out_ready
    );

    modport slave (
        input  address_out_data,
        input  address_out_valid,
        output address_out_ready
    );
endinterface

// File: rtl/ddr3_frame_address_sequencer.sv
// Triple-buffer frame manager: rotates writer/latest/reader DDR3 buffers and, per reader
// frame request, emits one tagged start address for each horizontal third of the frame.
module ddr3_frame_address_sequencer #(
    parameter logic [26:0] buffer_base   = 27'd0,
    parameter logic [26:0] buffer_stride = 27'd32768,
    parameter logic [26:0] third_stride  = 27'd16,
    parameter int          num_thirds    = 3
) (
    input  logic        ddr3clk,
    input  logic        ddr3clk_reset_n,
    input  logic        wr_frame_done,
    output logic [26:0] wr_base_address,
    input  logic        rd_frame_request,
    ddr3_frame_address_sequencer_if.master addr_out,
    output logic [7:0]  frames_dropped,
    output logic        frame_pending
);

    typedef enum logic {ST_IDLE, ST_EMIT} state_t;

    localparam logic [1:0] last_third = 2'(num_thirds - 1);

    state_t      state_reg, state_next;
    logic [1:0]  third_reg, third_next;
    logic [1:0]  write_idx_reg, write_idx_next;
    logic [1:0]  latest_idx_reg, latest_idx_next;
    logic [1:0]  read_idx_reg, read_idx_next;
    logic        latest_valid_reg, latest_valid_next;
    logic        req_pending_reg, req_pending_next;
    logic [7:0]  dropped_reg, dropped_next;
    logic [26:0] wr_base_reg;

    logic [26:0] base_tab [4];
    logic [2:0]  free_buf;

    // Buffer base table, wrapping modulo the 27-bit word address space.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_base
            assign base_tab[gi] = buffer_base + 27'(gi) * buffer_stride;
        end
    endgenerate

    always_comb begin
        state_next        = state_reg;
        third_next        = third_reg;
        latest_idx_next   = latest_idx_reg;
        latest_valid_next = latest_valid_reg;
        read_idx_next     = read_idx_reg;
        req_pending_next  = req_pending_reg;
        dropped_next      = dropped_reg;

        // A completed frame always displaces an unread older one, even when it is taken at once.
        if (wr_frame_done) begin
            latest_idx_next   = write_idx_reg;
            latest_valid_next = 1'b1;
            if (latest_valid_reg && dropped_reg != 8'hff) begin
                dropped_next = dropped_reg + 8'd1;
            end
        end

        case (state_reg)
            ST_IDLE: begin
                if ((rd_frame_request || req_pending_reg) && latest_valid_next) begin
                    read_idx_next     = latest_idx_next;
                    latest_valid_next = 1'b0;
                    req_pending_next  = 1'b0;
                    third_next        = 2'd0;
                    state_next        = ST_EMIT;
                end else if (rd_frame_request) begin
                    req_pending_next = 1'b1;
                end
            end
            ST_EMIT: begin
                if (rd_frame_request) begin
                    req_pending_next = 1'b1;
                end
                if (addr_out.address_out_ready) begin
                    if (third_reg == last_third) begin
                        third_next = 2'd0;
                        state_next = ST_IDLE;
                    end else begin
                        third_next = third_reg + 2'd1;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Writer takes the lowest buffer held by neither the reader nor a valid latest frame.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_free
            assign free_buf[gi] = (read_idx_next != 2'(gi)) &&
                                  !(latest_valid_next && (latest_idx_next == 2'(gi)));
        end
    endgenerate

    always_comb begin
        write_idx_next = 2'd2;
        if (free_buf[1]) write_idx_next = 2'd1;
        if (free_buf[0]) write_idx_next = 2'd0;
    end

    always_ff @(posedge ddr3clk or negedge ddr3clk_reset_n) begin
        if (!ddr3clk_reset_n) begin
            state_reg        <= ST_IDLE;
            third_reg        <= 2'd0;
            write_idx_reg    <= 2'd0;
            latest_idx_reg   <= 2'd1;
            read_idx_reg     <= 2'd2;
            latest_valid_reg <= 1'b0;
            req_pending_reg  <= 1'b0;
            dropped_reg      <= 8'd0;
            wr_base_reg      <= buffer_base;
        end else begin
            state_reg        <= state_next;
            third_reg        <= third_next;
            write_idx_reg    <= write_idx_next;
            latest_idx_reg   <= latest_idx_next;
            read_idx_reg     <= read_idx_next;
            latest_valid_reg <= latest_valid_next;
            req_pending_reg  <= req_pending_next;
            dropped_reg      <= dropped_next;
            wr_base_reg      <= base_tab[write_idx_next];
        end
    end

    assign wr_base_address            = wr_base_reg;
    assign frames_dropped             = dropped_reg;
    assign frame_pending              = latest_valid_reg;
    assign addr_out.address_out_valid = (state_reg == ST_EMIT);
    // Data is purely registered state, so it stays put while the sink stalls.
    assign addr_out.address_out_data  = (state_reg == ST_EMIT) ?
        {third_reg, base_tab[read_idx_reg] + 27'(third_reg) * third_stride} : 29'd0;

endmodule

// File: tb/tb_ddr3_frame_address_sequencer.sv
// Randomized and directed bench for the triple-buffer address sequencer with a queue scoreboard.
module tb_ddr3_frame_address_sequencer;

    localparam longint BASE    = 0;
    localparam longint STRIDE  = 32768;
    localparam longint TSTRIDE = 16;
    localparam int     NT      = 3;

    logic        ddr3clk = 1'b0;
    logic        ddr3clk_reset_n = 1'b0;
    logic        wr_frame_done = 1'b0;
    logic        rd_frame_request = 1'b0;
    logic [26:0] wr_base_address;
    logic [7:0]  frames_dropped;
    logic        frame_pending;

    ddr3_frame_address_sequencer_if bus ();

    ddr3_frame_address_sequencer dut (
        .ddr3clk          (ddr3clk),
        .ddr3clk_reset_n  (ddr3clk_reset_n),
        .wr_frame_done    (wr_frame_done),
        .wr_base_address  (wr_base_address),
        .rd_frame_request (rd_frame_request),
        .addr_out         (bus),
        .frames_dropped   (frames_dropped),
        .frame_pending    (frame_pending)
    );

    always #5 ddr3clk = ~ddr3clk;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [28:0] exp_q [$];
    logic [28:0] log_q [$];
    bit          log_en = 0;

    // Reference model: abstract buffer roles plus count of words still owed to the readers.
    int m_w, m_l, m_r, m_dropped, m_words_left;
    bit m_lv, m_pend;

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [26:0] base_of(int i);
        longint v;
        v = BASE + longint'(i) * STRIDE;
        return v[26:0];
    endfunction

    function automatic int lowest_free(int r, int l, bit lv);
        for (int i = 0; i < 3; i++) begin
            if (i != r && !(lv && i == l)) return i;
        end
        return -1;
    endfunction

    // Scoreboard monitor: one line per accepted word; stalled words must match the head.
    always @(negedge ddr3clk) begin
        if (ddr3clk_reset_n && bus.address_out_valid) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_word: got 0x%0h expected no word", bus.address_out_data);
            end else if (bus.address_out_ready) begin
                logic [28:0] e;
                e = exp_q.pop_front();
                check("word", 64'(bus.address_out_data), 64'(e));
                if (log_en) log_q.push_back(bus.address_out_data);
                $display("word tag=%0d addr=0x%07h expected=0x%08h t=%0t",
                         bus.address_out_data[28:27], bus.address_out_data[26:0], e, $time);
            end else begin
                check("held_word", 64'(bus.address_out_data), 64'(exp_q[0]));
            end
        end
    end

    task automatic model_reset();
        m_w = 0; m_l = 1; m_r = 2; m_lv = 0; m_pend = 0;
        m_dropped = 0; m_words_left = 0;
        exp_q.delete();
        log_q.delete();
    endtask

    // Called away from the clock edge: check state left by the previous edge, drive, predict.
    task automatic step(bit d, bit q, bit rdy);
        bit busy;
        busy = (m_words_left > 0);
        check("valid", 64'(bus.address_out_valid), 64'(busy));
        check("wr_base", 64'(wr_base_address), 64'(base_of(m_w)));
        check("dropped", 64'(frames_dropped), 64'(m_dropped));
        check("pending", 64'(frame_pending), 64'(m_lv));
        wr_frame_done = d;
        rd_frame_request = q;
        bus.address_out_ready = rdy;
        if (busy && rdy) m_words_left--;
        if (d) begin
            if (m_lv && m_dropped < 255) m_dropped++;
            m_l = m_w;
            m_lv = 1;
        end
        if (!busy && (q || m_pend) && m_lv) begin
            m_r = m_l; m_lv = 0; m_pend = 0; m_words_left = NT;
            for (int t = 0; t < NT; t++) begin
                logic [26:0] a;
                logic [1:0]  tg;
                a  = 27'(longint'(base_of(m_r)) + longint'(t) * TSTRIDE);
                tg = 2'(t);
                exp_q.push_back({tg, a});
            end
        end else if (q) begin
            m_pend = 1;
        end
        m_w = lowest_free(m_r, m_l, m_lv);
        @(posedge ddr3clk);
        #1;
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) step(0, 0, 1);
    endtask

    task automatic do_reset();
        ddr3clk_reset_n = 1'b0;
        wr_frame_done = 0;
        rd_frame_request = 0;
        bus.address_out_ready = 1;
        model_reset();
        repeat (2) @(posedge ddr3clk);
        #1;
        check("rst_valid", 64'(bus.address_out_valid), 64'd0);
        check("rst_data", 64'(bus.address_out_data), 64'd0);
        check("rst_wr_base", 64'(wr_base_address), 64'(base_of(0)));
        check("rst_dropped", 64'(frames_dropped), 64'd0);
        check("rst_pending", 64'(frame_pending), 64'd0);
        ddr3clk_reset_n = 1'b1;
    endtask

    initial begin
        bus.address_out_ready = 1;

        // Single frame, straight through.
        do_reset();
        log_en = 1;
        step(1, 0, 1);
        check("t1_wr_base", 64'(wr_base_address), 64'd32768);
        step(0, 1, 1);
        idle(5);
        log_en = 0;
        check("t1_count", 64'(log_q.size()), 64'd3);
        if (log_q.size() == 3) begin
            check("t1_w0", 64'(log_q[0]), 64'h0000000);
            check("t1_w1", 64'(log_q[1]), 64'h8000010);
            check("t1_w2", 64'(log_q[2]), 64'h10000020);
        end

        // Overwrite of an unread frame.
        do_reset();
        log_en = 1;
        step(1, 0, 1);
        step(1, 0, 1);
        check("t2_dropped", 64'(frames_dropped), 64'd1);
        check("t2_wr_base", 64'(wr_base_address), 64'd0);
        step(0, 1, 1);
        idle(5);
        log_en = 0;
        check("t2_count", 64'(log_q.size()), 64'd3);
        if (log_q.size() == 3) begin
            check("t2_w0", 64'(log_q[0]), 64'h0008000);
            check("t2_w2", 64'(log_q[2]), 64'h10008020);
        end

        // Request before any frame exists is held pending.
        do_reset();
        log_en = 1;
        step(0, 1, 1);
        idle(3);
        check("t3_no_words", 64'(log_q.size()), 64'd0);
        step(1, 0, 1);
        idle(5);
        log_en = 0;
        check("t3_count", 64'(log_q.size()), 64'd3);
        if (log_q.size() > 0) check("t3_w0", 64'(log_q[0]), 64'h0000000);

        // Done and request together: the fresh frame is taken, no drop.
        do_reset();
        step(1, 1, 1);
        check("t4_wr_base", 64'(wr_base_address), 64'd32768);
        check("t4_dropped", 64'(frames_dropped), 64'd0);
        idle(5);

        // Sink stalls five cycles on word 1.
        do_reset();
        log_en = 1;
        step(1, 0, 1);
        step(0, 1, 1);
        step(0, 0, 1);
        for (int i = 0; i < 5; i++) step(0, 0, 0);
        check("t5_held", 64'(bus.address_out_data), 64'h8000010);
        idle(5);
        log_en = 0;
        check("t5_count", 64'(log_q.size()), 64'd3);
        for (int i = 0; i < log_q.size(); i++) check("t5_tag", 64'(log_q[i][28:27]), 64'(i));

        // Drop counter saturation, then reset in the middle of an emission.
        do_reset();
        for (int i = 0; i < 300; i++) step(1, 0, 1);
        check("t6_saturate", 64'(frames_dropped), 64'd255);
        step(0, 1, 1);
        step(0, 0, 0);
        ddr3clk_reset_n = 1'b0;
        #1;
        check("t7_async_valid", 64'(bus.address_out_valid), 64'd0);
        check("t7_async_wr_base", 64'(wr_base_address), 64'd0);
        do_reset();

        // Randomized traffic against the reference model.
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 9) < 7);
        end
        for (int i = 0; i < 20 && (exp_q.size() > 0 || m_words_left > 0); i++) step(0, 0, 1);
        idle(2);
        check("drain_empty", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
